// File: rtl/pmp_walker.sv
// pmp_walker: walks PMP entries one per cycle for a latched request and returns fault/hit/entry over valid/ready
module pmp_walker #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_type,
  input  logic                     req_priv_m,
  input  logic [8*NUM_ENTRIES-1:0] pmpcfg,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
  input  logic                     cfg_we,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_fault,
  output logic                     resp_hit,
  output logic [IDX_W-1:0]         resp_entry
);
  typedef enum logic [1:0] {IDLE, WALK, RESP} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, entry_q, entry_d, prev;
  logic [29:0] addr_q, addr_d;
  logic [1:0] type_q, type_d;
  logic priv_q, priv_d, fault_q, fault_d, hit_q, hit_d;
  logic [7:0] cfg_i;
  logic [31:0] a, pa, lo;
  logic match, perm, hit_fault, last, unused_ok;
  assign unused_ok = ^{req_addr[1:0], cfg_i[6:5]};
  assign req_ready = rst_n && state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_fault = fault_q;
  assign resp_hit = hit_q;
  assign resp_entry = entry_q;
  always_comb begin
    prev = idx_q - 1'b1;
    cfg_i = pmpcfg[idx_q*8 +: 8];
    pa = pmpaddr[idx_q*32 +: 32];
    lo = (idx_q == '0) ? 32'd0 : pmpaddr[prev*32 +: 32];
    a = {2'b00, addr_q};
    match = cfg_i[4:3] == 2'd1 ? (a >= lo && a < pa) :
            cfg_i[4:3] == 2'd2 ? (a == pa) :
            cfg_i[4:3] == 2'd3 ? (((a ^ pa) & ~(pa ^ (pa + 32'd1))) == 32'd0) : 1'b0;
    perm = type_q == 2'd0 ? cfg_i[0] : type_q == 2'd1 ? cfg_i[1] : type_q == 2'd2 ? cfg_i[2] : 1'b0;
    hit_fault = type_q == 2'd3 || (!(priv_q && !cfg_i[7]) && !perm);
    last = idx_q == IDX_W'(NUM_ENTRIES - 1);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    addr_d = addr_q;
    type_d = type_q;
    priv_d = priv_q;
    fault_d = fault_q;
    hit_d = hit_q;
    entry_d = entry_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WALK;
        idx_d = '0;
        addr_d = req_addr[31:2];
        type_d = req_type;
        priv_d = req_priv_m;
      end
      WALK: if (cfg_we) begin
        idx_d = '0;
      end else if (match) begin
        state_d = RESP;
        fault_d = hit_fault;
        hit_d = 1'b1;
        entry_d = idx_q;
      end else if (last) begin
        state_d = RESP;
        fault_d = type_q == 2'd3 || !priv_q;
        hit_d = 1'b0;
        entry_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      addr_q <= '0;
      type_q <= '0;
      priv_q <= 1'b0;
      fault_q <= 1'b0;
      hit_q <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      type_q <= type_d;
      priv_q <= priv_d;
      fault_q <= fault_d;
      hit_q <= hit_d;
      entry_q <= entry_d;
    end
  end
endmodule
